// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared opcode, immediate-type and legality constants for the decode stage
package decode_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_JALR    = 3'b000;
    localparam logic [2:0] F3_BR_BAD0 = 3'b010;
    localparam logic [2:0] F3_BR_BAD1 = 3'b011;
    localparam logic [2:0] F3_LD_BAD0 = 3'b011;
    localparam logic [2:0] F3_LD_BAD1 = 3'b110;
    localparam logic [2:0] F3_LD_BAD2 = 3'b111;
    localparam logic [2:0] F3_ST_MIN_BAD = 3'b011;

endpackage

// File: rtl/decode_if.sv
// rtl/decode_if.sv - fetch-side and execute-side handshake bundle of the decode stage
// master: fetch/execute environment (drives in_*, out_ready); slave: decode_stage.
interface decode_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [6:0]      out_opcode;
    logic [2:0]      out_func3;
    logic [6:0]      out_func7;
    logic [4:0]      out_rs1_addr;
    logic [4:0]      out_rs2_addr;
    logic [4:0]      out_rd_addr;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_imm_type;
    logic            out_illegal;
    logic [XLEN-1:0] out_pc;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_opcode, out_func3, out_func7,
               out_rs1_addr, out_rs2_addr, out_rd_addr, out_imm,
               out_imm_type, out_illegal, out_pc
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_opcode, out_func3, out_func7,
               out_rs1_addr, out_rs2_addr, out_rd_addr, out_imm,
               out_imm_type, out_illegal, out_pc
    );
endinterface

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - combinational RV32I immediate extraction with sign extension to XLEN
// Ports: instr (raw word) -> imm (XLEN, sign-extended), imm_type (encoding of format).
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_type_e       imm_type
);
    logic [31:0] imm32;

    always_comb begin
        imm32    = '0;
        imm_type = IMM_NONE;
        case (instr[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
                imm32    = {{20{instr[31]}}, instr[31:20]};
                imm_type = IMM_I;
            end
            OPC_STORE: begin
                imm32    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                imm_type = IMM_S;
            end
            OPC_BRANCH: begin
                imm32    = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
                imm_type = IMM_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm32    = {instr[31:12], 12'b0};
                imm_type = IMM_U;
            end
            OPC_JAL: begin
                imm32    = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
                imm_type = IMM_J;
            end
            default: begin
                imm32    = '0;
                imm_type = IMM_NONE;
            end
        endcase
    end

    // Every format carries its sign in bit 31, so a single signed widening covers
    // XLEN=64 for all types, U included.
    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - single-register RV32I decode stage with legality check and retire counter
// Ports: clk, rst (async, active-high), flush, bus (decode_if.slave: in_* from fetch,
// out_* to execute), decode_count (bundles handed to execute, wraps).
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter bit ENABLE_SYSTEM = 1'b1,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    decode_if.slave          bus,
    output logic [CNT_W-1:0] decode_count
);
    logic            valid_q;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] imm_q;
    logic [XLEN-1:0] pc_q;
    imm_type_e       imm_type_q;
    logic            illegal_q;

    logic [XLEN-1:0] imm_d;
    imm_type_e       imm_type_d;
    logic            illegal_d;
    logic            in_xfer;
    logic            out_xfer;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opc = bus.in_instr[6:0];
    assign f3  = bus.in_instr[14:12];
    assign f7  = bus.in_instr[31:25];

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr    (bus.in_instr),
        .imm      (imm_d),
        .imm_type (imm_type_d)
    );

    always_comb begin
        illegal_d = 1'b0;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL: illegal_d = 1'b0;
            OPC_JALR:   illegal_d = (f3 != F3_JALR);
            OPC_BRANCH: illegal_d = (f3 == F3_BR_BAD0) || (f3 == F3_BR_BAD1);
            OPC_LOAD:   illegal_d = (f3 == F3_LD_BAD0) || (f3 == F3_LD_BAD1) || (f3 == F3_LD_BAD2);
            OPC_STORE:  illegal_d = (f3 >= F3_ST_MIN_BAD);
            OPC_OP_IMM: begin
                // Only the shift-immediates carry a func7 field; other OP-IMM
                // encodings use those bits as immediate.
                if (f3 == F3_SLL)
                    illegal_d = (f7 != F7_BASE);
                else if (f3 == F3_SR)
                    illegal_d = (f7 != F7_BASE) && (f7 != F7_ALT);
            end
            OPC_OP: begin
                illegal_d = !((f7 == F7_BASE) ||
                              ((f7 == F7_ALT) && ((f3 == F3_ADD_SUB) || (f3 == F3_SR))));
            end
            OPC_SYSTEM: illegal_d = !ENABLE_SYSTEM;
            default:    illegal_d = 1'b1;
        endcase
    end

    assign bus.in_ready  = (!valid_q || bus.out_ready) && !flush;
    assign bus.out_valid = valid_q && !flush;
    assign in_xfer       = bus.in_valid && bus.in_ready;
    assign out_xfer      = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            instr_q      <= '0;
            imm_q        <= '0;
            pc_q         <= '0;
            imm_type_q   <= IMM_NONE;
            illegal_q    <= 1'b0;
            decode_count <= '0;
        end else begin
            if (flush)
                valid_q <= 1'b0;
            else if (in_xfer)
                valid_q <= 1'b1;
            else if (out_xfer)
                valid_q <= 1'b0;

            if (in_xfer) begin
                instr_q    <= bus.in_instr;
                imm_q      <= imm_d;
                pc_q       <= bus.in_pc;
                imm_type_q <= imm_type_d;
                illegal_q  <= illegal_d;
            end

            if (out_xfer)
                decode_count <= decode_count + CNT_W'(1);
        end
    end

    assign bus.out_opcode   = instr_q[6:0];
    assign bus.out_rd_addr  = instr_q[11:7];
    assign bus.out_func3    = instr_q[14:12];
    assign bus.out_rs1_addr = instr_q[19:15];
    assign bus.out_rs2_addr = instr_q[24:20];
    assign bus.out_func7    = instr_q[31:25];
    assign bus.out_imm      = imm_q;
    assign bus.out_imm_type = imm_type_q;
    assign bus.out_illegal  = illegal_q;
    assign bus.out_pc       = pc_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage (two configurations in lockstep)
module tb_decode_stage;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [2:0]  itype;
        logic        ill_on;
        logic        ill_off;
    } vec_t;

    typedef struct {
        vec_t        v;
        logic [63:0] pc;
    } exp_t;

    localparam int NV = 19;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [63:0] in_pc = '0;
    logic        out_ready = 1'b1;
    logic [31:0] dc0;
    logic [3:0]  dc1;

    vec_t        tbl [NV];
    vec_t        cur_vec;
    exp_t        sbq [$];
    int          checks = 0;
    int          errors = 0;
    int unsigned exp_cnt = 0;
    logic        held, exp_ir, exp_ov, acc;

    decode_if #(.XLEN(32)) bus0 ();
    decode_if #(.XLEN(64)) bus1 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.in_instr  = in_instr;
    assign bus0.in_pc     = in_pc[31:0];
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.in_instr  = in_instr;
    assign bus1.in_pc     = in_pc;
    assign bus1.out_ready = out_ready;

    decode_stage #(.XLEN(32), .ENABLE_SYSTEM(1'b1), .CNT_W(32)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus0), .decode_count(dc0));
    decode_stage #(.XLEN(64), .ENABLE_SYSTEM(1'b0), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus1), .decode_count(dc1));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_bundle(input string tag, input exp_t e, input logic ill, input int xlen,
                              input logic [31:0] fields, input logic [63:0] imm,
                              input logic [2:0] ty, input logic il, input logic [63:0] pc);
        logic [31:0] i;
        logic [63:0] eimm, epc;
        i    = e.v.instr;
        eimm = (xlen == 64) ? {{32{e.v.imm[31]}}, e.v.imm} : {32'h0, e.v.imm};
        epc  = (xlen == 64) ? e.pc : {32'h0, e.pc[31:0]};
        chk({tag, "_fields"}, fields, {i[6:0], i[14:12], i[31:25], i[19:15], i[24:20], i[11:7]});
        chk({tag, "_imm"}, imm, eimm);
        chk({tag, "_type"}, ty, e.v.itype);
        chk({tag, "_illegal"}, il, ill);
        chk({tag, "_pc"}, pc, epc);
    endtask

    // Scoreboard: occupancy of the stage is modelled by the queue (0 or 1 entry).
    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
            exp_cnt = 0;
            chk("rst_out_valid", {bus0.out_valid, bus1.out_valid}, 2'b00);
            chk("rst_count", {dc0, dc1}, 36'h0);
        end else begin
            held   = (sbq.size() != 0);
            exp_ir = (!held || out_ready) && !flush;
            exp_ov = held && !flush;
            chk("in_ready", {bus0.in_ready, bus1.in_ready}, {exp_ir, exp_ir});
            chk("out_valid", {bus0.out_valid, bus1.out_valid}, {exp_ov, exp_ov});
            chk("count0", dc0, exp_cnt);
            chk("count1", dc1, exp_cnt[3:0]);
            if (exp_ov) begin
                chk_bundle("d0", sbq[0], sbq[0].v.ill_on, 32,
                    {bus0.out_opcode, bus0.out_func3, bus0.out_func7, bus0.out_rs1_addr,
                     bus0.out_rs2_addr, bus0.out_rd_addr},
                    {32'h0, bus0.out_imm}, bus0.out_imm_type, bus0.out_illegal,
                    {32'h0, bus0.out_pc});
                chk_bundle("d1", sbq[0], sbq[0].v.ill_off, 64,
                    {bus1.out_opcode, bus1.out_func3, bus1.out_func7, bus1.out_rs1_addr,
                     bus1.out_rs2_addr, bus1.out_rd_addr},
                    bus1.out_imm, bus1.out_imm_type, bus1.out_illegal, bus1.out_pc);
            end
            if (flush) begin
                sbq.delete();
            end else begin
                if (held && out_ready) begin
                    void'(sbq.pop_front());
                    exp_cnt++;
                end
                if (in_valid && exp_ir)
                    sbq.push_back('{cur_vec, in_pc});
            end
        end
    end

    task automatic present(input int idx, input logic [63:0] pc);
        in_valid = 1'b1;
        in_instr = tbl[idx].instr;
        cur_vec  = tbl[idx];
        in_pc    = pc;
    endtask

    task automatic send(input int idx, input logic [63:0] pc);
        int n;
        logic a;
        n = 0;
        present(idx, pc);
        do begin
            @(negedge clk);
            a = bus0.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!a && n < 50);
        chk("send_accept", a, 1'b1);
        in_valid = 1'b0;
    endtask

    initial begin
        //         instr          imm           type  ill(SYS on) ill(SYS off)
        tbl[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 1'b0}; // addi x1,x0,-1
        tbl[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0, 1'b0}; // beq x0,x0,-4
        tbl[2]  = '{32'h123452B7, 32'h12345000, 3'd4, 1'b0, 1'b0}; // lui x5,0x12345
        tbl[3]  = '{32'h00000000, 32'h00000000, 3'd0, 1'b1, 1'b1}; // all zero
        tbl[4]  = '{32'h00000073, 32'h00000000, 3'd1, 1'b0, 1'b1}; // ecall
        tbl[5]  = '{32'hFE20AC23, 32'hFFFFFFF8, 3'd2, 1'b0, 1'b0}; // sw x2,-8(x1)
        tbl[6]  = '{32'hFFDFF0EF, 32'hFFFFFFFC, 3'd5, 1'b0, 1'b0}; // jal x1,-4
        tbl[7]  = '{32'h000010E7, 32'h00000000, 3'd1, 1'b1, 1'b1}; // jalr func3=1
        tbl[8]  = '{32'h402081B3, 32'h00000000, 3'd0, 1'b0, 1'b0}; // sub
        tbl[9]  = '{32'h402091B3, 32'h00000000, 3'd0, 1'b1, 1'b1}; // OP alt func7, func3=1
        tbl[10] = '{32'h022081B3, 32'h00000000, 3'd0, 1'b1, 1'b1}; // OP func7=1
        tbl[11] = '{32'h4030D093, 32'h00000403, 3'd1, 1'b0, 1'b0}; // srai x1,x1,3
        tbl[12] = '{32'h40309093, 32'h00000403, 3'd1, 1'b1, 1'b1}; // slli with func7=0100000
        tbl[13] = '{32'h00003083, 32'h00000000, 3'd1, 1'b1, 1'b1}; // load func3=3
        tbl[14] = '{32'h00002063, 32'h00000000, 3'd3, 1'b1, 1'b1}; // branch func3=2
        tbl[15] = '{32'h00003023, 32'h00000000, 3'd2, 1'b1, 1'b1}; // store func3=3
        tbl[16] = '{32'h80000017, 32'h80000000, 3'd4, 1'b0, 1'b0}; // auipc x0,0x80000
        tbl[17] = '{32'hFFF02083, 32'hFFFFFFFF, 3'd1, 1'b0, 1'b0}; // lw x1,-1(x0)
        tbl[18] = '{32'h0230D093, 32'h00000023, 3'd1, 1'b1, 1'b1}; // srli func7=1
        cur_vec = tbl[0];

        repeat (3) @(posedge clk);
        #1;
        chk("reset_imm_type", {bus0.out_imm_type, bus1.out_imm_type}, 6'h0);
        chk("reset_illegal", {bus0.out_illegal, bus1.out_illegal}, 2'b00);
        rst = 1'b0;

        // addi, then count check after the output transfer edge
        send(0, 64'h1000);
        @(posedge clk);
        #1;
        chk("count_after_addi", dc0, 32'd1);

        // whole table back-to-back with execute always ready
        for (int i = 1; i < NV; i++)
            send(i, 64'h2000 + 64'(4 * i));
        repeat (2) @(posedge clk);
        #1;
        chk("count_after_table", dc0, 32'(NV));

        // stall: valid held with execute not ready for three cycles
        out_ready = 1'b0;
        send(5, 64'h3000);
        present(6, 64'h3004);
        repeat (3) @(posedge clk);
        #1;
        chk("stall_count", dc0, 32'(NV));
        out_ready = 1'b1;
        send(6, 64'h3004);
        repeat (2) @(posedge clk);
        #1;
        chk("release_count", dc0, 32'(NV + 2));

        // flush with a held bundle and a new instruction presented
        out_ready = 1'b0;
        send(2, 64'h4000);
        present(1, 64'h4004);
        flush = 1'b1;
        #2;
        chk("flush_out_valid", {bus0.out_valid, bus1.out_valid}, 2'b00);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #2;
        chk("after_flush_out_valid", {bus0.out_valid, bus1.out_valid}, 2'b00);
        chk("after_flush_count", dc0, 32'(NV + 2));

        // asynchronous reset in the middle of a stall
        out_ready = 1'b0;
        send(0, 64'h5000);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", {bus0.out_valid, bus1.out_valid}, 2'b00);
        chk("arst_count", {dc0, dc1}, 36'h0);
        chk("arst_imm", {bus0.out_imm, bus1.out_imm}, 96'h0);
        chk("arst_type_ill", {bus0.out_imm_type, bus0.out_illegal, bus1.out_imm_type, bus1.out_illegal}, 8'h0);
        chk("arst_pc", {bus0.out_pc, bus1.out_pc}, 96'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;

        // random traffic over the table with back-pressure and occasional flush
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            acc = in_valid && bus0.in_ready;
            @(posedge clk);
            #1;
            if (!in_valid || acc) begin
                present($urandom_range(0, NV - 1), {$urandom, $urandom});
                in_valid = ($urandom_range(0, 3) != 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
        end

        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 128'(sbq.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
